// File: rtl/tx_pkg.sv
// Shared types and default sizing for the transmit arbiter and its transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

  localparam int TX_D    = 8;
  localparam int TX_NREQ = 4;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner select: rotate eligibility so ptr sits at bit 0, take the
// lowest set bit, then rotate the index back.
module rr_select #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  localparam logic [IW:0] NREQ_W = NREQ[IW:0];

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic              found;

  always_comb begin
    dbl    = {elig, elig} >> ptr;
    rot    = dbl[NREQ-1:0];
    any    = |elig;
    off    = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        off   = i[IW-1:0];
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx    = sum[IW-1:0];
    onehot = '0;
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among NREQ byte requesters;
// latches the winner's byte and sequences the send/rdy handshake.
module tx_arbiter
  import tx_pkg::*;
#(
  parameter int NREQ = TX_NREQ,
  parameter int D    = TX_D,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*D-1:0] req_data,
  input  logic [NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]   grant,
  input  logic              tx_rdy,
  output logic              tx_send,
  output logic [D-1:0]      tx_data,
  output logic              busy,
  output logic [IW-1:0]     owner,
  output logic [1:0]        dbg_state,
  output logic [IW-1:0]     dbg_ptr
);

  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  // Handshake with the transmitter: tx_send is held high until the transmitter
  // signals acceptance by dropping tx_rdy; the frame is finished when tx_rdy
  // returns high, and only then may the next byte be granted.
  arb_state_t       state_q;
  logic [IW-1:0]    ptr_q;
  logic [NREQ-1:0]  grant_q;
  logic             send_q;
  logic [D-1:0]     data_q;
  logic             busy_q;
  logic [IW-1:0]    owner_q;

  logic [NREQ-1:0]  elig;
  logic             sel_any;
  logic [IW-1:0]    sel_idx;
  logic [NREQ-1:0]  sel_onehot;
  logic [D-1:0]     win_data;

  assign elig     = req & req_mask;
  assign win_data = req_data[int'(sel_idx)*D +: D];

  rr_select #(.NREQ(NREQ), .IW(IW)) u_sel (
    .elig   (elig),
    .ptr    (ptr_q),
    .any    (sel_any),
    .idx    (sel_idx),
    .onehot (sel_onehot)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      grant_q <= '0;
      case (state_q)
        IDLE: begin
          if (tx_rdy && sel_any) begin
            grant_q <= sel_onehot;
            data_q  <= win_data;
            owner_q <= sel_idx;
            send_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_rdy) begin
            send_q  <= 1'b0;
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // data_q is untouched here: the transmitter reads it bit by bit all frame.
          if (tx_rdy) begin
            busy_q  <= 1'b0;
            ptr_q   <= (owner_q == LAST) ? '0 : owner_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          send_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign tx_send   = send_q;
  assign tx_data   = data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a scripted transmitter drives tx_rdy and each
// scenario task checks the arbiter outputs against hand-derived values.
module tb_tx_arbiter;
  import tx_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic [3:0]  grant;
  logic        tx_rdy;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  owner;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  tx_arbiter #(.NREQ(4), .D(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .grant     (grant),
    .tx_rdy    (tx_rdy),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .busy      (busy),
    .owner     (owner),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 4'b0 && n < 50);
    n_checks++;
    if (grant == 4'b0) begin
      n_fail++;
      $display("FAIL wait_grant: no grant within %0d cycles", n);
    end
  endtask

  // Transmitter accepts send, stays busy 10 cycles, then returns ready.
  task automatic run_frame();
    tx_rdy = 1'b0;
    repeat (10) tick();
    tx_rdy = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    req      = 4'b0;
    req_mask = 4'b1111;
    req_data = {8'h43, 8'hA5, 8'h21, 8'h10};
    tx_rdy   = 1'b1;
    tick();
    tick();
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b want 0", tx_send); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); end
    n_checks++; if (dbg_state !== 2'(IDLE)) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    tick();
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", tx_data); end
    n_checks++; if (tx_send !== 1'b1) begin n_fail++; $display("FAIL single_send: got %b want 1", tx_send); end
    n_checks++; if (owner !== 2'd2) begin n_fail++; $display("FAIL single_owner: got %0d want 2", owner); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    req    = 4'b0;
    tx_rdy = 1'b0;
    tick();
    n_checks++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL single_send_fall: got %b want 0", tx_send); end
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL single_grant_pulse: got %b want 0000", grant); end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (tx_data !== 8'hA5 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got data=%h busy=%b want a5/1", i, tx_data, busy);
      end
    end
    tx_rdy = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    n_checks++; if (dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", dbg_ptr); end
    n_checks++; if (dbg_state !== 2'(IDLE)) begin n_fail++; $display("FAIL single_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_bytes [4];
    logic [3:0] exp_g;
    int n;
    exp_bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      exp_g = 4'b0001 << (k % 4);
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant, exp_g); end
      n_checks++; if (tx_data !== exp_bytes[k % 4]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, tx_data, exp_bytes[k % 4]); end
      n_checks++; if (owner !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_owner[%0d]: got %0d want %0d", k, owner, k % 4); end
      n_checks++; if (n !== 1) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d cycles want 1", k, n); end
      run_frame();
    end
    req = 4'b0;
  endtask

  task automatic test_mask();
    logic [3:0] exp_g;
    int n;
    req_mask = 4'b1010;
    req      = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n);
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL mask_grant[%0d]: got %b want %b", k, grant, exp_g); end
      run_frame();
    end
    req      = 4'b0;
    req_mask = 4'b1111;
  endtask

  task automatic test_stall();
    req_data = {8'h43, 8'h32, 8'h21, 8'h5A};
    req      = 4'b0001;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL stall_grant: got %b want 0001", grant); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (tx_send !== 1'b1 || tx_data !== 8'h5A || grant !== 4'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got send=%b data=%h grant=%b want 1/5a/0000", i, tx_send, tx_data, grant);
      end
    end
    req = 4'b0;
    run_frame();
  endtask

  task automatic test_not_ready();
    tx_rdy = 1'b0;
    req    = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0 || tx_send !== 1'b0) begin
        n_fail++;
        $display("FAIL notready_idle[%0d]: got grant=%b send=%b want 0000/0", i, grant, tx_send);
      end
    end
    tx_rdy = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL notready_grant: got %b want 0001", grant); end
    req = 4'b0;
    run_frame();
  endtask

  task automatic test_reset_mid_frame();
    req = 4'b0100;
    tick();
    req    = 4'b0;
    tx_rdy = 1'b0;
    tick();
    tick();
    n_checks++; if (dbg_state !== 2'(WAIT_DONE)) begin n_fail++; $display("FAIL midrst_pre_state: got %0d want 2", dbg_state); end
    reset = 1'b0;
    tick();
    n_checks++; if (tx_send !== 1'b0) begin n_fail++; $display("FAIL midrst_send: got %b want 0", tx_send); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL midrst_grant: got %b want 0000", grant); end
    n_checks++; if (owner !== 2'd0) begin n_fail++; $display("FAIL midrst_owner: got %0d want 0", owner); end
    n_checks++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL midrst_ptr: got %0d want 0", dbg_ptr); end
    n_checks++; if (dbg_state !== 2'(IDLE)) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dbg_state); end
    reset  = 1'b1;
    tx_rdy = 1'b1;
    req    = 4'b1000;
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL midrst_regrant: got %b want 1000", grant); end
    n_checks++; if (owner !== 2'd3) begin n_fail++; $display("FAIL midrst_owner3: got %0d want 3", owner); end
    req = 4'b0;
    run_frame();
  endtask

  task automatic test_all_masked();
    req_mask = 4'b0000;
    req      = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0 || tx_send !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL masked[%0d]: got grant=%b send=%b busy=%b want 0000/0/0", i, grant, tx_send, busy);
      end
    end
    req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_stall();
    test_not_ready();
    test_reset_mid_frame();
    test_all_masked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one serial transmitter FSM (send/data/rdy handshake, D-bit frames) among NREQ byte requesters.
- Sits between client logic and the transmitter.
  - Latches the winning requester's byte.
  - Drives send until the transmitter drops rdy.
  - Waits for rdy to return before the next grant.

Parameters:
- NREQ, 4, number of requesters (2..16).
- D, 8, data byte width; must match the transmitter's D.
- IW, $clog2(NREQ), width of the owner index.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset (reset==0 clears state on the next posedge).
- req  input  NREQ  per-requester request; level, held until granted.
- req_data  input  NREQ*D  packed bytes; requester i occupies bits [i*D +: D].
- req_mask  input  NREQ  enable mask; a masked-off (0) requester is never granted.
- grant  output  NREQ  one-hot, one-cycle pulse: byte from that requester has been latched.
- tx_rdy  input  1  rdy from the transmitter.
- tx_send  output  1  send to the transmitter.
- tx_data  output  D  data to the transmitter; stable for the entire frame.
- busy  output  1  high from grant until the transmitter returns to ready.
- owner  output  IW  index of the current or most recent grantee.

Behaviour:
- All outputs registered.
- Reset values:
  - grant=0, tx_send=0, tx_data=0, busy=0, owner=0.
  - Round-robin pointer ptr=0, state=IDLE.
- Reset mid-frame returns to IDLE immediately. The arbiter does not wait for tx_rdy.
- Eligible vector: elig = req & req_mask.
- Winner: the first set bit of elig searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 (wraps modulo NREQ).
- State IDLE:
  - When tx_rdy==1 and elig!=0 at edge t:
    - grant<=onehot(winner) and tx_data<=req_data[winner].
    - owner<=winner, tx_send<=1, busy<=1, state<=ISSUE.
  - grant, tx_data, tx_send and busy are visible in cycle t+1.
  - If tx_rdy==0 in IDLE (transmitter still ending a frame), no grant is issued.
- State ISSUE:
  - grant<=0 after its one-cycle pulse.
  - tx_send held high while tx_rdy==1.
  - On the first sampled tx_rdy==0: tx_send<=0, state<=WAIT_DONE.
  - No timeout; send stays asserted until accepted.
- State WAIT_DONE:
  - tx_data held constant, because the transmitter reads data[count-1] throughout the frame.
  - On tx_rdy==1: busy<=0, ptr<=(owner+1) mod NREQ, state<=IDLE.
- Back-to-back: the next grant is issued at the earliest on the edge after the arbiter re-enters IDLE. There is one idle cycle between frames, minimum.
- Request dropped before grant: not an error; it simply loses eligibility. Requests arriving during ISSUE or WAIT_DONE wait for IDLE.
- Mask change mid-frame has no effect on the current frame.
- A requester holding req after its grant is treated as a new byte request. Clients must deassert req in the grant cycle if they have a single byte.
- All requesters masked: the arbiter stays in IDLE with tx_send=0.
- ptr advances only on frame completion, never on grant. Fairness: any continuously eligible requester is served within NREQ frames.
- Illegal state encoding: recover to IDLE (default branch).

Decomposition:
- Package tx_pkg holds:
  - typedef enum logic[1:0] arb_state_t {IDLE, ISSUE, WAIT_DONE}.
  - Default constants TX_D=8 and TX_NREQ=4, shared with the transmitter instance.
- Sub-module rr_select (combinational):
  - Inputs: elig[NREQ], ptr[IW].
  - Outputs: any, idx[IW], onehot[NREQ].
  - Implemented as a double-width rotate plus priority encode.
- The arbiter FSM, registers and data mux stay in tx_arbiter.

Test Plan:
1. Single request: reset low 2 cycles then high; req=4'b0100, req_data[2]=8'hA5, tx_rdy=1.
   - Next cycle: grant=4'b0100, tx_data=8'hA5, tx_send=1, owner=2.
   - Drive tx_rdy=0: tx_send falls next cycle.
   - Drive tx_rdy=1 after 10 cycles: busy falls, ptr=3.
2. Round-robin with all requesters continuously active: req=4'b1111, transmitter model completes each frame in 11 cycles.
   - Grant order 0,1,2,3,0.
   - tx_data equals each requester's byte (8'h10, 8'h21, 8'h32, 8'h43).
3. Mask: req=4'b1111, req_mask=4'b1010 → grants alternate 1,3,1,3; requesters 0 and 2 are never granted.
4. Transmitter stall: hold tx_rdy=1 for 5 cycles after grant.
   - tx_send stays high all 5 cycles.
   - tx_data stays 8'h5A.
   - No second grant is issued.
5. Not-ready at entry: tx_rdy=0 while in IDLE with req=4'b0001 → no grant until tx_rdy=1; grant arrives exactly one cycle later.
6. Reset mid-frame: assert reset=0 during WAIT_DONE.
   - Next edge: tx_send=0, busy=0, grant=0, owner=0, ptr=0.
   - After reset release with req=4'b1000: grant=4'b1000.
